// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared definitions for the SR flip-flop bank driver.
//   - STATE_W / *_ENC : FSM state width and encodings
//   - state_t         : FSM state type built from those encodings
//   - cnt_width()     : bit width of a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package sr_drv_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] IDLE_ENC   = 3'd0;
   localparam logic [STATE_W-1:0] DRIVE_ENC  = 3'd1;
   localparam logic [STATE_W-1:0] SETTLE_ENC = 3'd2;
   localparam logic [STATE_W-1:0] DONE_ENC   = 3'd3;
   localparam logic [STATE_W-1:0] ERR_ENC    = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = IDLE_ENC,
      ST_DRIVE  = DRIVE_ENC,
      ST_SETTLE = SETTLE_ENC,
      ST_DONE   = DONE_ENC,
      ST_ERR    = ERR_ENC
   } state_t;

   // Never returns less than 1 so that a counter for max_val=0 stays legal.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// -----------------------------------------------------------------------------
// sr_ff_driver_if
// Command and flop-bank signals between a target source / SR flop bank
// (master side) and sr_ff_driver (slave side).
//   tgt_valid, tgt_data : target request from the source
//   tgt_ready           : driver can accept a target
//   q_fb                : Q outputs of the SR flop bank
//   s, r                : set / reset excitation to the flop bank
//   busy, done, err     : transaction status; done/err are one-cycle pulses
//   mismatch            : target ^ Q captured when a settle timeout fires
// -----------------------------------------------------------------------------
interface sr_ff_driver_if #(
   parameter int WIDTH = 4
);
   logic             tgt_valid;
   logic             tgt_ready;
   logic [WIDTH-1:0] tgt_data;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] mismatch;

   modport master (
      output tgt_valid, tgt_data, q_fb,
      input  tgt_ready, s, r, busy, done, err, mismatch
   );

   modport slave (
      input  tgt_valid, tgt_data, q_fb,
      output tgt_ready, s, r, busy, done, err, mismatch
   );
endinterface

// File: rtl/sr_excitation.sv
// -----------------------------------------------------------------------------
// sr_excitation
// Per-bit SR excitation that moves a flop from cur toward tgt.
//   tgt    : requested state
//   cur    : current Q
//   s_next : set where tgt=1 and cur=0
//   r_next : reset where tgt=0 and cur=1
// S and R are never both set on a bit, since they need opposite cur values.
// -----------------------------------------------------------------------------
module sr_excitation #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] tgt,
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] s_next,
   output logic [WIDTH-1:0] r_next
);
   assign s_next = tgt & ~cur;
   assign r_next = ~tgt & cur;
endmodule

// File: rtl/sr_ff_driver.sv
// -----------------------------------------------------------------------------
// sr_ff_driver
// Drives a WIDTH-bit SR flop bank to a requested target, one target per
// valid/ready transaction: pulse S/R for PULSE_CYCLES, then wait for Q to
// match and report done (or err on settle timeout).
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sr_ff_driver_if.slave (tgt_valid/tgt_ready/tgt_data, q_fb,
//         s, r, busy, done, err, mismatch)
// Optional feature: define SR_DRV_TIMEOUT_EN to add a TIMEOUT-cycle settle
// limit that ends in an err pulse with mismatch captured. Without it SETTLE
// waits for a match indefinitely and err/mismatch read 0.
// -----------------------------------------------------------------------------
module sr_ff_driver
   import sr_drv_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int PULSE_CYCLES = 1,
   parameter int TIMEOUT      = 16
) (
   input logic clk,
   input logic rst,
   sr_ff_driver_if.slave bus
);

   if (PULSE_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
      $error("sr_ff_driver: PULSE_CYCLES and TIMEOUT must both be at least 1");
   end

   localparam int PULSE_W = cnt_width(PULSE_CYCLES);

   state_t             state, state_nxt;
   logic               ready_q;
   logic [WIDTH-1:0]   tgt;
   logic [WIDTH-1:0]   s_q, r_q;
   logic [WIDTH-1:0]   s_next, r_next;
   logic [PULSE_W-1:0] pulse_cnt;
   logic               accept;
   logic               timeout;

   // The excitation is computed from the Q snapshot at accept time; the
   // registered s_q/r_q then hold that snapshot, so later Q motion is ignored.
   sr_excitation #(.WIDTH(WIDTH)) u_exc (
      .tgt    (bus.tgt_data),
      .cur    (bus.q_fb),
      .s_next (s_next),
      .r_next (r_next)
   );

   // ready_q is only ever high in IDLE, so this is the full handshake.
   assign accept = bus.tgt_valid & ready_q;

   // NOTE: always_comb assigns every output a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b1;
      bus.done  = 1'b0;
      bus.err   = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.busy = 1'b0;
            if (accept) begin
               state_nxt = (bus.tgt_data == bus.q_fb) ? ST_DONE : ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (pulse_cnt == '0) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (bus.q_fb == tgt) state_nxt = ST_DONE;
            else if (timeout)    state_nxt = ST_ERR;
         end
         ST_DONE: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_ERR: begin
`ifdef SR_DRV_TIMEOUT_EN
            bus.err   = 1'b1;
`endif
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ready_q   <= 1'b0;
         s_q       <= '0;
         r_q       <= '0;
         pulse_cnt <= '0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == ST_IDLE);

         if (accept) begin
            pulse_cnt <= PULSE_W'(PULSE_CYCLES - 1);
         end else if (state == ST_DRIVE && pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - 1'b1;
         end

         // Load on accept (zero when target already matches), hold through
         // DRIVE, clear on any other next state.
         if (accept) begin
            s_q <= s_next;
            r_q <= r_next;
         end else if (state_nxt != ST_DRIVE) begin
            s_q <= '0;
            r_q <= '0;
         end
      end
   end

   // NOTE: tgt is a data register that is only read after an accept has
   // written it, so it deliberately carries no reset.
   always_ff @(posedge clk) begin
      if (accept) tgt <= bus.tgt_data;
   end

`ifdef SR_DRV_TIMEOUT_EN
   localparam int SETTLE_W = cnt_width(TIMEOUT);

   logic [SETTLE_W-1:0] settle_cnt;
   logic [WIDTH-1:0]    mismatch_q;

   // settle_cnt is 0 in every non-SETTLE state, so it starts from 0 on entry
   // and equals (settle cycles elapsed - 1) during SETTLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         mismatch_q <= '0;
      end else begin
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
         if (accept) begin
            mismatch_q <= '0;
         end else if (state == ST_SETTLE && state_nxt == ST_ERR) begin
            mismatch_q <= tgt ^ bus.q_fb;
         end
      end
   end

   assign timeout      = (settle_cnt == SETTLE_W'(TIMEOUT - 1));
   assign bus.mismatch = mismatch_q;
`else
   assign timeout      = 1'b0;
   assign bus.mismatch = '0;
`endif

   assign bus.tgt_ready = ready_q;
   assign bus.s         = s_q;
   assign bus.r         = r_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_driver
// Two drivers (PULSE_CYCLES=1 and 3), each looped back through a 4-bit SR flop
// bank model. A transaction-level reference model predicts every output each
// cycle; directed scenarios add hand-computed expectations, followed by
// randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_sr_ff_driver;

   localparam int W       = 4;
   localparam int TIMEOUT = 16;
   localparam int PC [2]  = '{1, 3};

   typedef struct {
      logic         ready, busy, done, err;
      logic [W-1:0] s, r, mm, tgt;
      int           drive_left;   // excitation cycles still to come
      bit           settling;
      int           settle_n;     // settle cycles already spent without match
   } model_t;

   logic         clk = 1'b0;
   logic         rst   [2];
   logic         vld   [2];
   logic [W-1:0] dat   [2];
   logic [W-1:0] stuck [2];
   logic [W-1:0] q     [2];
   logic [W-1:0] fb    [2];
   logic         rdy   [2];
   logic         busy_o[2];
   logic         done_o[2];
   logic         err_o [2];
   logic [W-1:0] s_o   [2];
   logic [W-1:0] r_o   [2];
   logic [W-1:0] mm_o  [2];

   model_t m [2];
   int     checks   = 0;
   int     failures = 0;
   bit     cmp_en   = 1'b0;

   always #5 clk = ~clk;

   sr_ff_driver_if #(.WIDTH(W)) if_a ();
   sr_ff_driver_if #(.WIDTH(W)) if_b ();

   sr_ff_driver #(.WIDTH(W), .PULSE_CYCLES(1), .TIMEOUT(TIMEOUT)) dut_a (
      .clk (clk),
      .rst (rst[0]),
      .bus (if_a)
   );

   sr_ff_driver #(.WIDTH(W), .PULSE_CYCLES(3), .TIMEOUT(TIMEOUT)) dut_b (
      .clk (clk),
      .rst (rst[1]),
      .bus (if_b)
   );

   assign if_a.tgt_valid = vld[0];
   assign if_a.tgt_data  = dat[0];
   assign if_a.q_fb      = fb[0];
   assign if_b.tgt_valid = vld[1];
   assign if_b.tgt_data  = dat[1];
   assign if_b.q_fb      = fb[1];

   assign rdy[0] = if_a.tgt_ready;  assign rdy[1] = if_b.tgt_ready;
   assign busy_o[0] = if_a.busy;    assign busy_o[1] = if_b.busy;
   assign done_o[0] = if_a.done;    assign done_o[1] = if_b.done;
   assign err_o[0] = if_a.err;      assign err_o[1] = if_b.err;
   assign s_o[0] = if_a.s;          assign s_o[1] = if_b.s;
   assign r_o[0] = if_a.r;          assign r_o[1] = if_b.r;
   assign mm_o[0] = if_a.mismatch;  assign mm_o[1] = if_b.mismatch;

   // SR flop bank models; stuck bits read back as 0.
   assign fb[0] = q[0] & ~stuck[0];
   assign fb[1] = q[1] & ~stuck[1];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) q[k] <= '0;
         else        q[k] <= (q[k] | s_o[k]) & ~r_o[k];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per clock edge from the pre-edge inputs.
   task automatic model_tick(input model_t c, input int p, input logic rst_i,
                             input logic v, input logic [W-1:0] d,
                             input logic [W-1:0] qv, output model_t n);
      n      = c;
      n.done = 1'b0;
      n.err  = 1'b0;
      if (rst_i) begin
         n.ready = 1'b0; n.busy = 1'b0;
         n.s = '0; n.r = '0; n.mm = '0;
         n.drive_left = 0; n.settling = 1'b0; n.settle_n = 0;
      end else if (c.ready && v) begin
         n.tgt = d; n.mm = '0; n.ready = 1'b0; n.busy = 1'b1;
         if (d == qv) begin
            n.done = 1'b1; n.s = '0; n.r = '0;
         end else begin
            n.s = d & ~qv; n.r = ~d & qv; n.drive_left = p;
         end
      end else if (c.drive_left > 0) begin
         n.drive_left = c.drive_left - 1;
         if (n.drive_left == 0) begin
            n.s = '0; n.r = '0; n.settling = 1'b1; n.settle_n = 0;
         end
      end else if (c.settling) begin
         if (qv == c.tgt) begin
            n.settling = 1'b0; n.done = 1'b1;
         end else begin
            n.settle_n = c.settle_n + 1;
`ifdef SR_DRV_TIMEOUT_EN
            if (n.settle_n == TIMEOUT) begin
               n.settling = 1'b0; n.err = 1'b1; n.mm = c.tgt ^ qv;
            end
`endif
         end
      end else begin
         // Idle, or the cycle right after a done/err pulse.
         n.busy = 1'b0; n.ready = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         model_tick(m[k], PC[k], rst[k], vld[k], dat[k], fb[k], m[k]);
      end
   end

   // Compare process: every output of both drivers, every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "a" : "b";
            check({p, ".tgt_ready"}, 32'(rdy[k]),    32'(m[k].ready));
            check({p, ".busy"},      32'(busy_o[k]), 32'(m[k].busy));
            check({p, ".done"},      32'(done_o[k]), 32'(m[k].done));
            check({p, ".err"},       32'(err_o[k]),  32'(m[k].err));
            check({p, ".s"},         32'(s_o[k]),    32'(m[k].s));
            check({p, ".r"},         32'(r_o[k]),    32'(m[k].r));
            check({p, ".mismatch"},  32'(mm_o[k]),   32'(m[k].mm));
            check({p, ".s_and_r"},   32'(s_o[k] & r_o[k]), 32'(0));
         end
      end
   end

   // Present a target and hold it until accepted; returns at the negedge of
   // the first cycle after the accepting edge.
   task automatic send(input int k, input logic [W-1:0] d);
      int n;
      @(negedge clk);
      vld[k] = 1'b1;
      dat[k] = d;
      n = 0;
      while (rdy[k] !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("send_ready_seen", 32'(rdy[k]), 32'(1));
      @(negedge clk);
      vld[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int budget, output int cyc);
      cyc = 0;
      while (done_o[k] !== 1'b1 && err_o[k] !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 32'(done_o[k]), 32'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  cyc;
      bit  saw_done;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; vld[k] = 1'b0; dat[k] = '0; stuck[k] = '0;
      end
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;

      // Reset state.
      check("rst_ready", 32'(rdy[0]), 32'(0));
      check("rst_s",     32'(s_o[0]), 32'(0));
      check("rst_busy",  32'(busy_o[0]), 32'(0));
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(rdy[0]), 32'(1));

      // Scenario 1: 0000 -> 1010.
      send(0, 4'b1010);
      check("s1_s", 32'(s_o[0]), 32'(4'b1010));
      check("s1_r", 32'(r_o[0]), 32'(4'b0000));
      wait_done(0, 20, cyc);
      check("s1_latency", 32'(cyc), 32'(2));
      check("s1_q", 32'(fb[0]), 32'(4'b1010));
      @(negedge clk);
      check("s1_ready_back", 32'(rdy[0]), 32'(1));

      // Scenario 2: 1010 -> 0110.
      send(0, 4'b0110);
      check("s2_s", 32'(s_o[0]), 32'(4'b0100));
      check("s2_r", 32'(r_o[0]), 32'(4'b1000));
      wait_done(0, 20, cyc);
      check("s2_q", 32'(fb[0]), 32'(4'b0110));

      // Scenario 3: target already matches, done at N+1.
      send(0, 4'b0110);
      check("s3_done", 32'(done_o[0]), 32'(1));
      check("s3_s", 32'(s_o[0]), 32'(0));
      check("s3_r", 32'(r_o[0]), 32'(0));
      @(negedge clk);
      check("s3_ready_back", 32'(rdy[0]), 32'(1));

      // Scenario 6: 1111 held while busy on 0011 must not be latched.
      send(0, 4'b0011);
      check("s6_s", 32'(s_o[0]), 32'(4'b0001));
      check("s6_r", 32'(r_o[0]), 32'(4'b0100));
      vld[0] = 1'b1;
      dat[0] = 4'b1111;
      wait_done(0, 20, cyc);
      check("s6_q_first", 32'(fb[0]), 32'(4'b0011));
      send(0, 4'b1111);
      check("s6_s2", 32'(s_o[0]), 32'(4'b1100));
      check("s6_r2", 32'(r_o[0]), 32'(4'b0000));
      wait_done(0, 20, cyc);

      // Scenario 4: bit0 stuck at 0, target 0001.
      @(negedge clk);
      stuck[0] = 4'b0001;
      send(0, 4'b0001);
      check("s4_s", 32'(s_o[0]), 32'(4'b0001));
      check("s4_r", 32'(r_o[0]), 32'(4'b1110));
      saw_done = 1'b0;
`ifdef SR_DRV_TIMEOUT_EN
      cyc = 1;
      while (err_o[0] !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done_o[0] === 1'b1) saw_done = 1'b1;
      end
      check("s4_err", 32'(err_o[0]), 32'(1));
      check("s4_err_cycle", 32'(cyc), 32'(18));
      check("s4_mismatch", 32'(mm_o[0]), 32'(4'b0001));
      check("s4_no_done", 32'(saw_done), 32'(0));
      @(negedge clk);
      check("s4_mismatch_held", 32'(mm_o[0]), 32'(4'b0001));
      check("s4_ready_back", 32'(rdy[0]), 32'(1));
`else
      repeat (40) begin
         @(negedge clk);
         if (done_o[0] === 1'b1) saw_done = 1'b1;
      end
      check("s4_busy_held", 32'(busy_o[0]), 32'(1));
      check("s4_not_ready", 32'(rdy[0]), 32'(0));
      check("s4_no_done", 32'(saw_done), 32'(0));
`endif
      stuck[0] = '0;
      rst[0]   = 1'b1;
      @(negedge clk);
      rst[0]   = 1'b0;

      // Scenario 5: PULSE_CYCLES=3, reset during the 2nd DRIVE cycle.
      send(1, 4'b0101);
      check("s5_s_c1", 32'(s_o[1]), 32'(4'b0101));
      @(negedge clk);
      check("s5_s_c2", 32'(s_o[1]), 32'(4'b0101));
      rst[1] = 1'b1;
      @(negedge clk);
      check("s5_s_clr",  32'(s_o[1]),    32'(0));
      check("s5_r_clr",  32'(r_o[1]),    32'(0));
      check("s5_nodone", 32'(done_o[1]), 32'(0));
      check("s5_noerr",  32'(err_o[1]),  32'(0));
      check("s5_ready0", 32'(rdy[1]),    32'(0));
      rst[1] = 1'b0;
      @(negedge clk);
      check("s5_ready1", 32'(rdy[1]), 32'(1));

      // Randomized traffic on both drivers against the model.
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            vld[k] = ($urandom_range(0, 3) != 0);
            dat[k] = W'($urandom);
            rst[k] = ($urandom_range(0, 63) == 0);
         end
`ifdef SR_DRV_TIMEOUT_EN
         if (c % 40 == 0) stuck[0] = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
`endif
      end

      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         vld[k] = 1'b0; rst[k] = 1'b0; stuck[k] = '0;
      end
      repeat (30) @(negedge clk);
      check("final_idle_a", 32'(rdy[0]), 32'(1));
      check("final_idle_b", 32'(rdy[1]), 32'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
